// File: rtl/decade_counter_pkg.sv
// decade_counter_pkg: shared BCD digit type, limits and load sanitising helper
package decade_counter_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;
    // Non-BCD nibbles collapse to zero so a digit can never hold 10..15
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t v);
        return (v > BCD_MAX) ? BCD_MIN : v;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one MOD-10 up/down stage with clear, load and step enable
module bcd_digit
    import decade_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       step_en,
    input  logic       up_dn,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min
);
    assign at_max = (digit == BCD_MAX);
    assign at_min = (digit == BCD_MIN);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            digit <= BCD_MIN;
        else if (clr)
            digit <= BCD_MIN;
        else if (load)
            digit <= bcd_sanitize(load_val);
        else if (step_en)
            digit <= up_dn ? (at_max ? BCD_MIN : digit + 4'd1)
                           : (at_min ? BCD_MAX : digit - 4'd1);
    end
endmodule

// File: rtl/decade_counter.sv
// decade_counter: NUM_DIGITS cascaded synchronous BCD digits with terminal count.
// Optional sticky full-wrap output enabled by DECADE_COUNTER_WRAP_FLAG_EN.
module decade_counter
    import decade_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count,
`ifdef DECADE_COUNTER_WRAP_FLAG_EN
    output logic                    wrap_flag,
`endif
    output logic                    tc
);
    logic [NUM_DIGITS:0]   step;
    logic [NUM_DIGITS-1:0] at_max;
    logic [NUM_DIGITS-1:0] at_min;
    // Each stage steps only when every lower stage sits at its wrap point
    assign step[0] = en;
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[4*k +: 4]),
            .step_en  (step[k]),
            .up_dn    (up_dn),
            .digit    (count[4*k +: 4]),
            .at_max   (at_max[k]),
            .at_min   (at_min[k])
        );
        assign step[k+1] = step[k] & (up_dn ? at_max[k] : at_min[k]);
    end
    assign tc = step[NUM_DIGITS];
`ifdef DECADE_COUNTER_WRAP_FLAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wrap_flag <= 1'b0;
        else if (clr || load)
            wrap_flag <= 1'b0;
        else if (tc)
            wrap_flag <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_decade_counter.sv
// tb_decade_counter: directed checks of a 1-digit and a 2-digit decade counter
module tb_decade_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic       tc;
    logic       en_b = 1'b0, up_b = 1'b1, clr_b = 1'b0, load_b = 1'b0;
    logic [7:0] load_val_b = 8'd0;
    logic [7:0] count_b;
    logic       tc_b;
    int         n_chk = 0;
    int         n_fail = 0;
    int         exp_cnt;
`ifdef DECADE_COUNTER_WRAP_FLAG_EN
    logic       wrap_flag;
    logic       wrap_flag_b;
`endif

    always #5 clk = ~clk;

    decade_counter u_dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count),
`ifdef DECADE_COUNTER_WRAP_FLAG_EN
        .wrap_flag(wrap_flag),
`endif
        .tc(tc)
    );

    decade_counter #(.NUM_DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .clr(clr_b), .load(load_b),
        .load_val(load_val_b), .count(count_b),
`ifdef DECADE_COUNTER_WRAP_FLAG_EN
        .wrap_flag(wrap_flag_b),
`endif
        .tc(tc_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #10;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_tc", 32'(tc), 32'd0);
        chk("reset_count2", 32'(count_b), 32'd0);
        #2 rst = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp_cnt = (exp_cnt + 1) % 10;
            chk("run_count", 32'(count), 32'(exp_cnt));
            chk("run_tc", 32'(tc), 32'(exp_cnt == 9));
            chk("run_bcd", 32'(count <= 4'd9), 32'd1);
        end
        // async reset mid-count at 4, low for 10 ns
        #2 rst = 1'b0;
        #1 chk("async_rst", 32'(count), 32'd0);
        #9 rst = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            exp_cnt = (exp_cnt + 1) % 10;
            chk("rerun_count", 32'(count), 32'(exp_cnt));
        end
        // load 2 then count down 1,0,9,8
        load = 1'b1; load_val = 4'd2;
        @(negedge clk);
        chk("load2", 32'(count), 32'd2);
        load = 1'b0; up_dn = 1'b0;
        exp_cnt = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_cnt = (exp_cnt + 9) % 10;
            chk("down_count", 32'(count), 32'(exp_cnt));
            chk("down_tc", 32'(tc), 32'(exp_cnt == 0));
        end
        en = 1'b0;
        #1 chk("hold_tc", 32'(tc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_count", 32'(count), 32'd8);
            chk("hold_tc", 32'(tc), 32'd0);
        end
        // load and clear priority
        en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
        @(negedge clk);
        chk("load7", 32'(count), 32'd7);
        load_val = 4'hC;
        @(negedge clk);
        chk("load_nonbcd", 32'(count), 32'd0);
        load_val = 4'd5; clr = 1'b1;
        @(negedge clk);
        chk("clr_over_load", 32'(count), 32'd0);
        clr = 1'b0;
        @(negedge clk);
        chk("load5", 32'(count), 32'd5);
        load = 1'b0;
        @(negedge clk);
        chk("up6", 32'(count), 32'd6);
        up_dn = 1'b0;
        @(negedge clk);
        chk("dir_change", 32'(count), 32'd5);
        // two-digit cascade
        load_b = 1'b1; load_val_b = 8'h98; en_b = 1'b1; up_b = 1'b1;
        @(negedge clk);
        chk("c2_load98", 32'(count_b), 32'h98);
        chk("c2_tc98", 32'(tc_b), 32'd0);
        load_b = 1'b0;
        @(negedge clk);
        chk("c2_99", 32'(count_b), 32'h99);
        chk("c2_tc99", 32'(tc_b), 32'd1);
        @(negedge clk);
        chk("c2_wrap00", 32'(count_b), 32'h00);
        chk("c2_tc00", 32'(tc_b), 32'd0);
        load_b = 1'b1; load_val_b = 8'h00; up_b = 1'b0;
        @(negedge clk);
        chk("c2_tc_down00", 32'(tc_b), 32'd1);
        load_b = 1'b0;
        @(negedge clk);
        chk("c2_down99", 32'(count_b), 32'h99);
        load_b = 1'b1; load_val_b = 8'h10;
        @(negedge clk);
        load_b = 1'b0;
        @(negedge clk);
        chk("c2_borrow09", 32'(count_b), 32'h09);
        load_b = 1'b1; load_val_b = 8'h3A;
        @(negedge clk);
        chk("c2_load_nonbcd", 32'(count_b), 32'h30);
        load_b = 1'b0; en_b = 1'b0;
`ifdef DECADE_COUNTER_WRAP_FLAG_EN
        up_dn = 1'b1; clr = 1'b1;
        @(negedge clk);
        chk("wf_clr", 32'(wrap_flag), 32'd0);
        clr = 1'b0; load = 1'b1; load_val = 4'd9;
        @(negedge clk);
        chk("wf_load", 32'(wrap_flag), 32'd0);
        load = 1'b0;
        @(negedge clk);
        chk("wf_count0", 32'(count), 32'd0);
        chk("wf_set", 32'(wrap_flag), 32'd1);
        @(negedge clk);
        chk("wf_sticky", 32'(wrap_flag), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        chk("wf_clr2", 32'(wrap_flag), 32'd0);
        clr = 1'b0; up_dn = 1'b0;
        @(negedge clk);
        chk("wf_down9", 32'(count), 32'd9);
        chk("wf_down_set", 32'(wrap_flag), 32'd1);
        load = 1'b1; load_val = 4'd3;
        @(negedge clk);
        chk("wf_load_clr", 32'(wrap_flag), 32'd0);
        load = 1'b0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
